// File: rtl/mem_fault_pkg.sv
// Shared types for the fault-injecting SRAM model: fault kinds, table entry layout
// and the per-bit write-time fault rule.
package mem_fault_pkg;

   localparam int HIT_W     = 16;
   localparam int FT_ADDR_W = 16;
   localparam int FT_BIT_W  = 6;

   typedef enum logic [1:0] {
      SA0     = 2'd0,
      SA1     = 2'd1,
      TF_RISE = 2'd2,
      TF_FALL = 2'd3
   } fault_type_e;

   typedef struct packed {
      logic                 valid;
      fault_type_e          ftype;
      logic [FT_ADDR_W-1:0] addr;
      logic [FT_BIT_W-1:0]  bit_pos;
   } fault_entry_t;

   // Returns {force_en, force_val} for one faulty bit being written.
   function automatic logic [1:0] write_force(input fault_type_e ftype,
                                              input logic old_bit,
                                              input logic new_bit);
      logic [1:0] res;
      res = 2'b00;
      case (ftype)
         SA0:     res = 2'b10;
         SA1:     res = 2'b11;
         TF_RISE: res = (!old_bit && new_bit) ? 2'b10 : 2'b00;
         TF_FALL: res = (old_bit && !new_bit) ? 2'b11 : 2'b00;
         default: res = 2'b00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_fault_table.sv
// Programmable fault table: entry registers plus lowest-index-wins per-bit match,
// producing write-path and read-path force masks for the addressed word.
module mem_fault_table
   import mem_fault_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int NUM_FAULTS = 4,
   parameter int IDX_W      = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
   parameter int BIT_W      = $clog2(DATA_W)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cfg_en,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_valid,
   input  logic [1:0]        cfg_type,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [BIT_W-1:0]  cfg_bit,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] new_word,
   output logic [DATA_W-1:0] wr_force_en,
   output logic [DATA_W-1:0] wr_force_val,
   output logic [DATA_W-1:0] rd_force_en,
   output logic [DATA_W-1:0] rd_force_val,
   output logic              any_hit
);

   fault_entry_t entries [NUM_FAULTS];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_FAULTS; i++) entries[i] <= '0;
      end else if (cfg_en && (int'(cfg_idx) < NUM_FAULTS)) begin
         entries[cfg_idx] <= '{valid:   cfg_valid,
                               ftype:   fault_type_e'(cfg_type),
                               addr:    FT_ADDR_W'(cfg_addr),
                               bit_pos: FT_BIT_W'(cfg_bit)};
      end
   end

   // Walk from the highest index down so the lowest matching entry is applied last.
   always_comb begin
      wr_force_en  = '0;
      wr_force_val = '0;
      rd_force_en  = '0;
      rd_force_val = '0;
      any_hit      = 1'b0;
      for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
         if (entries[i].valid && (entries[i].addr == FT_ADDR_W'(addr))) begin
            any_hit = 1'b1;
            for (int b = 0; b < DATA_W; b++) begin
               if (entries[i].bit_pos == FT_BIT_W'(b)) begin
                  {wr_force_en[b], wr_force_val[b]} =
                     write_force(entries[i].ftype, old_word[b], new_word[b]);
                  rd_force_en[b]  = (entries[i].ftype == SA0) || (entries[i].ftype == SA1);
                  rd_force_val[b] = (entries[i].ftype == SA1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/mem_fault_model.sv
// Single-port SRAM stand-in with runtime fault injection and a saturating count
// of accesses that touch a faulty word.
module mem_fault_model
   import mem_fault_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int NUM_FAULTS = 4,
   parameter int IDX_W      = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      CEN,
   input  logic                      WEN,
   input  logic [ADDR_W-1:0]         A,
   input  logic [DATA_W-1:0]         D,
   input  logic                      OEN,
   output logic [DATA_W-1:0]         Q,
   input  logic                      FCFG_EN,
   input  logic [IDX_W-1:0]          FCFG_IDX,
   input  logic                      FCFG_VALID,
   input  logic [1:0]                FCFG_TYPE,
   input  logic [ADDR_W-1:0]         FCFG_ADDR,
   input  logic [$clog2(DATA_W)-1:0] FCFG_BIT,
   output logic [HIT_W-1:0]          FAULT_HITS
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] q_reg;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] wr_word;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] wr_force_en;
   logic [DATA_W-1:0] wr_force_val;
   logic [DATA_W-1:0] rd_force_en;
   logic [DATA_W-1:0] rd_force_val;
   logic              any_hit;
   logic [HIT_W-1:0]  hits;

   mem_fault_table #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .NUM_FAULTS (NUM_FAULTS),
      .IDX_W      (IDX_W)
   ) u_table (
      .CLK          (CLK),
      .RST          (RST),
      .cfg_en       (FCFG_EN),
      .cfg_idx      (FCFG_IDX),
      .cfg_valid    (FCFG_VALID),
      .cfg_type     (FCFG_TYPE),
      .cfg_addr     (FCFG_ADDR),
      .cfg_bit      (FCFG_BIT),
      .addr         (A),
      .old_word     (old_word),
      .new_word     (D),
      .wr_force_en  (wr_force_en),
      .wr_force_val (wr_force_val),
      .rd_force_en  (rd_force_en),
      .rd_force_val (rd_force_val),
      .any_hit      (any_hit)
   );

   assign old_word = mem[A];
   assign wr_word  = (D & ~wr_force_en) | (wr_force_val & wr_force_en);
   // Stuck-at faults installed after the last write still show up on reads.
   assign rd_word  = (old_word & ~rd_force_en) | (rd_force_val & rd_force_en);

   always_ff @(posedge CLK) begin
      if (!CEN && !WEN) mem[A] <= wr_word;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_reg <= '0;
         hits  <= '0;
      end else if (!CEN) begin
         if (WEN) q_reg <= rd_word;
         if (any_hit && (hits != '1)) hits <= hits + 1'b1;
      end
   end

   assign Q          = OEN ? {DATA_W{1'bz}} : q_reg;
   assign FAULT_HITS = hits;

endmodule
